// File: rtl/ifmap_pkg.sv
// Shared geometry, packet layout and FSM encoding for the ping-pong ifmap streamer.
package ifmap_pkg;

    localparam int DEF_DEPTH_I        = 25;
    localparam int DEF_KERNEL         = 5;
    localparam int DEF_NUM_BANKS      = 2;
    localparam int DEF_PACKET_D_WIDTH = 40;
    localparam int DEF_DEST_W         = 4;
    localparam int DEF_ADDR_W         = 10;

    localparam int OUT_ROWS = DEF_DEPTH_I - DEF_KERNEL + 1;
    localparam int PKT_W    = DEF_DEST_W + DEF_PACKET_D_WIDTH;

    typedef struct packed {
        logic [DEF_DEST_W-1:0]         dest;
        logic [DEF_PACKET_D_WIDTH-1:0] payload;
    } pkt_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_ADV
    } state_t;

endpackage

// File: rtl/ifmap_bank_ram.sv
// One spike-map bank: per-bit writes, whole-row synchronous read.
module ifmap_bank_ram
    import ifmap_pkg::*;
#(
    parameter int DEPTH_I = DEF_DEPTH_I,
    parameter int ROW_W   = $clog2(DEF_DEPTH_I)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ROW_W-1:0]   wr_row,
    input  logic [ROW_W-1:0]   wr_col,
    input  logic               wr_bit,
    input  logic               rd_en,
    input  logic [ROW_W-1:0]   rd_row,
    output logic [DEPTH_I-1:0] rd_data
);

    logic [DEPTH_I-1:0] mem [DEPTH_I];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_row][wr_col] <= wr_bit;
    end

    // The read register doubles as the packet payload, so it must reset.
    always_ff @(posedge clk) begin
        if (rst)        rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_row];
    end

endmodule

// File: rtl/ifmap_pingpong_streamer.sv
// Two-bank ifmap buffer streaming KERNEL-row sliding windows as addressed packets.
module ifmap_pingpong_streamer
    import ifmap_pkg::*;
#(
    parameter int DEPTH_I        = DEF_DEPTH_I,
    parameter int KERNEL         = DEF_KERNEL,
    parameter int NUM_BANKS      = DEF_NUM_BANKS,
    parameter int PACKET_D_WIDTH = DEF_PACKET_D_WIDTH,
    parameter int DEST_W         = DEF_DEST_W,
    parameter int ADDR_W         = DEF_ADDR_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic                             wr_bank,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic                             wr_data,
    input  logic                             load_done,
    input  logic                             load_bank,
    output logic                             pkt_valid,
    input  logic                             pkt_ready,
    output logic [DEST_W+PACKET_D_WIDTH-1:0] pkt_data,
    output logic                             frame_done,
    output logic                             busy,
    output logic                             err
);

    localparam int N_ROWS = DEPTH_I - KERNEL + 1;
    localparam int ROW_W  = $clog2(DEPTH_I);
    localparam int J_W    = $clog2(N_ROWS);
    localparam int CELLS  = DEPTH_I * DEPTH_I;
    localparam int PAD_W  = PACKET_D_WIDTH - DEPTH_I;

    state_t               state, state_n;
    logic [J_W-1:0]       j_q;
    logic [DEST_W-1:0]    k_q, dest_q;
    logic                 cur_bank, rd_bank_q;
    logic [NUM_BANKS-1:0] bank_full;
    logic                 wr_fire, addr_ok, k_last, j_last;
    logic                 bank_done, rd_en;
    logic [ROW_W-1:0]     wr_row, wr_col, rd_row;
    logic [DEPTH_I-1:0]   rd_rows [NUM_BANKS];

    assign wr_ready = !rst && !bank_full[wr_bank];
    assign wr_fire  = wr_valid && wr_ready;
    assign addr_ok  = 32'(wr_addr) < CELLS;
    assign wr_row   = ROW_W'(wr_addr / ADDR_W'(DEPTH_I));
    assign wr_col   = ROW_W'(wr_addr % ADDR_W'(DEPTH_I));
    assign k_last   = k_q == DEST_W'(KERNEL - 1);
    assign j_last   = j_q == J_W'(N_ROWS - 1);
    assign rd_row   = ROW_W'(j_q) + ROW_W'(k_q);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        ifmap_bank_ram #(
            .DEPTH_I(DEPTH_I),
            .ROW_W  (ROW_W)
        ) u_ram (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_fire && addr_ok && wr_bank == 1'(b)),
            .wr_row (wr_row),
            .wr_col (wr_col),
            .wr_bit (wr_data),
            .rd_en  (rd_en && cur_bank == 1'(b)),
            .rd_row (rd_row),
            .rd_data(rd_rows[b])
        );
    end

    // rd_bank_q pins the payload mux so pkt_data only moves on a fetch.
    assign pkt_data = {dest_q, {PAD_W{1'b0}}, rd_rows[rd_bank_q]};

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (bank_full[cur_bank]) state_n = S_FETCH;
            S_FETCH: state_n = S_SEND;
            S_SEND:  if (pkt_ready) state_n = S_ADV;
            S_ADV:   state_n = (k_last && j_last) ? S_IDLE : S_FETCH;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        pkt_valid = 1'b0;
        busy      = 1'b1;
        rd_en     = 1'b0;
        bank_done = 1'b0;
        unique case (state)
            S_IDLE:  busy = 1'b0;
            S_FETCH: rd_en = 1'b1;
            S_SEND:  pkt_valid = 1'b1;
            S_ADV:   bank_done = k_last && j_last;
            default: busy = 1'b0;
        endcase
    end

    assign frame_done = bank_done && cur_bank == 1'(NUM_BANKS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            j_q       <= '0;
            k_q       <= '0;
            cur_bank  <= 1'b0;
            dest_q    <= '0;
            rd_bank_q <= 1'b0;
        end else begin
            if (rd_en) begin
                dest_q    <= k_q;
                rd_bank_q <= cur_bank;
            end
            if (state == S_ADV) begin
                if (!k_last) begin
                    k_q <= k_q + 1'b1;
                end else begin
                    k_q <= '0;
                    if (!j_last) begin
                        j_q <= j_q + 1'b1;
                    end else begin
                        j_q      <= '0;
                        cur_bank <= (cur_bank == 1'(NUM_BANKS - 1)) ? 1'b0 : cur_bank + 1'b1;
                    end
                end
            end
        end
    end

    // A write sampled alongside load_done uses the pre-set flag, so it lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= '0;
            err       <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (load_done && load_bank == 1'(b)) bank_full[b] <= 1'b1;
                if (bank_done && cur_bank == 1'(b))  bank_full[b] <= 1'b0;
            end
            if ((wr_fire && !addr_ok) || (load_done && bank_full[load_bank]))
                err <= 1'b1;
        end
    end

endmodule

// File: doc/ifmap_pingpong_streamer.md
Name: ifmap_pingpong_streamer

Overview:
- Clocked, parametrised successor of the CSP ifmap buffer. It holds an input spike map in two ping-pong banks, one bank per timestep.
- It streams KERNEL-row sliding windows as addressed packets toward the PE rows.
- Loading of one bank overlaps with streaming of the other, so consecutive frames pipeline without stalls.
- Sits between the spike loader (upstream) and the packet router/PE array (downstream).

Parameters:
- DEPTH_I, 25, ifmap side length (bits per row, rows per map)
- KERNEL, 5, window height; also the number of destination PE rows
- OUT_ROWS, DEPTH_I-KERNEL+1 (21), output rows per timestep
- NUM_BANKS, 2, ping-pong banks (timesteps per frame)
- PACKET_D_WIDTH, 40, payload width; must be >= DEPTH_I
- DEST_W, 4, destination field width; must satisfy 2^DEST_W >= KERNEL
- ADDR_W, 10, bit-address width; must satisfy 2^ADDR_W >= DEPTH_I*DEPTH_I

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid&&wr_ready
- wr_bank  in  1  target bank (0 = timestep 1, 1 = timestep 2)
- wr_addr  in  ADDR_W  bit address, row*DEPTH_I+col
- wr_data  in  1  spike bit
- load_done  in  1  one-cycle pulse: bank load_bank fully written
- load_bank  in  1  bank qualified by load_done
- pkt_valid  out  1  packet available
- pkt_ready  in  1  downstream accepts
- pkt_data  out  DEST_W+PACKET_D_WIDTH  {dest, zero-padded row bits; bit c = column c}
- frame_done  out  1  one-cycle pulse after the last packet of bank NUM_BANKS-1
- busy  out  1  streamer FSM not IDLE
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset values: wr_ready=0, pkt_valid=0, pkt_data=0, frame_done=0, busy=0, err=0. All bank_full flags clear; FSM in IDLE; counters zeroed. Memory contents are not reset.
- Storage: per bank, DEPTH_I rows of DEPTH_I bits. Writes are per bit; reads fetch a whole row in one cycle into the registered pkt_data.
- Write port:
  - wr_ready = !bank_full[wr_bank] (combinational).
  - An accepted write with wr_addr >= DEPTH_I*DEPTH_I is dropped and sets err.
- load_done on bank b:
  - Sets bank_full[b] next cycle.
  - If bank_full[b] is already set: ignored, and err is set.
  - If a write to b and load_done for b occur in the same cycle, the write lands first.
- FSM states: IDLE, FETCH, SEND, ADV.
  - IDLE: when bank_full[cur_bank] -> FETCH. cur_bank resets to 0.
  - FETCH (1 cycle): register row (j+k) of cur_bank into pkt_data payload; dest = k. -> SEND.
  - SEND: pkt_valid=1 and pkt_data held stable until pkt_ready. pkt_valid never drops without a handshake. On handshake -> ADV.
  - ADV: increment k. On k wrap (KERNEL-1 -> 0), increment j. On j wrap (OUT_ROWS-1 -> 0):
    - clear bank_full[cur_bank];
    - if cur_bank == NUM_BANKS-1, pulse frame_done and set cur_bank=0;
    - otherwise cur_bank+1.
    - Next state: FETCH if more packets remain in the bank, else IDLE.
- Ordering per bank: j outer, k inner. KERNEL*OUT_ROWS packets per bank (105 at defaults).
- Latency and throughput:
  - First pkt_valid appears 2 cycles after bank_full[0] sets (IDLE->FETCH->SEND).
  - With pkt_ready tied high: one packet per 3 cycles.
- Ping-pong: a bank becomes writable again the cycle after its bank_full clears, so bank 0 may be reloaded while bank 1 streams.
- Backpressure: pkt_ready low holds SEND indefinitely with no loss.
- rst mid-stream: next cycle pkt_valid=0, FSM=IDLE, all bank_full cleared; the partial frame is abandoned.
- err clears only on rst.

Decomposition:
- Shared package ifmap_pkg holds:
  - the packet typedef {dest, payload};
  - localparams PKT_W, OUT_ROWS and the default widths;
  - the FSM state enum.
- Sub-module ifmap_bank_ram: one bank with a per-bit write enable and a one-row synchronous read, instantiated NUM_BANKS times.
- FSM and counters live in the top level.

Test Plan:
- Load bank 0 with checkerboard (bit=(r+c)%2), load_done, pkt_ready=1 -> first pkt_data = {4'd0, 15'b0, row0 pattern}. Packet 5 is {dest 0, row1}. Exactly 105 packets are sent for bank 0.
- Load both banks (bank 1 = all ones), stream with pkt_ready=1 -> 210 packets in j/k order; bank 1 payloads are 25'h1FFFFFF; frame_done pulses once, the cycle after the 210th handshake.
- Random pkt_ready (30% high) -> same 105-packet sequence as the ready-high run; pkt_data stable whenever pkt_valid&&!pkt_ready.
- During bank 1 streaming, write and load_done bank 0 -> wr_ready=1 for bank 0 after bank 0 clears; wr_ready=0 for bank 1 writes; the second frame streams with no idle gap beyond IDLE->FETCH.
- wr_addr=625, and load_done twice on bank 0 -> err=1 and held; the memory row remains unchanged.
- rst asserted after the 40th packet -> pkt_valid=0, busy=0, wr_ready=1 the next cycle; a reload plus load_done restarts at {dest 0, row 0}.
